// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rst_seq_ctrl : releases per-stage resets in order, each gated on the prior
// stage's ready with a bounded wait; soft re-sequence and sticky timeout.
// Rev 1.0
// ----------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 255,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SW_RST_REQ,
  input  logic [NUM_STAGES-1:0] STAGE_DONE,
  output logic [NUM_STAGES-1:0] STAGE_RST,
  output logic                  SEQ_DONE,
  output logic                  SEQ_ERR,
  output logic [2:0]            CUR_STAGE
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_WAIT  = 2'd1,
    S_RUN   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_hold_last  = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_to_last    = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [2:0]           c_last_stage = 3'(NUM_STAGES - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  seq_done_q, seq_done_d;
  logic                  seq_err_q, seq_err_d;
  logic [2:0]            cur_stage_q, cur_stage_d;

  logic                  done_cur;
  logic [NUM_STAGES-1:0] next_mask;

  always_comb begin
    // Only the awaited stage's done bit is ever looked at.
    done_cur  = 1'b0;
    next_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cur_stage_q == 3'(i)) done_cur = STAGE_DONE[i];
      if (cur_stage_q + 3'd1 == 3'(i)) next_mask[i] = 1'b1;
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_rst_d = stage_rst_q;
    seq_done_d  = seq_done_q;
    seq_err_d   = seq_err_q;
    cur_stage_d = cur_stage_q;

    if (SW_RST_REQ) begin
      state_d     = S_HOLD;
      cnt_d       = '0;
      stage_rst_d = '1;
      seq_done_d  = 1'b0;
      seq_err_d   = 1'b0;
      cur_stage_d = 3'd0;
    end else begin
      case (state_q)
        S_HOLD: begin
          stage_rst_d = '1;
          if (cnt_q == c_hold_last) begin
            stage_rst_d = {{(NUM_STAGES-1){1'b1}}, 1'b0};
            cur_stage_d = 3'd0;
            cnt_d       = '0;
            state_d     = S_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        S_WAIT: begin
          // Done wins over a timeout landing on the same edge.
          if (done_cur) begin
            if (cur_stage_q == c_last_stage) begin
              seq_done_d = 1'b1;
              state_d    = S_RUN;
            end else begin
              stage_rst_d = stage_rst_q & ~next_mask;
              cur_stage_d = cur_stage_q + 3'd1;
              cnt_d       = '0;
            end
          end else if (cnt_q == c_to_last) begin
            stage_rst_d = '1;
            seq_err_d   = 1'b1;
            state_d     = S_ERROR;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      stage_rst_q <= '1;
      seq_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      cur_stage_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_rst_q <= stage_rst_d;
      seq_done_q  <= seq_done_d;
      seq_err_q   <= seq_err_d;
      cur_stage_q <= cur_stage_d;
    end
  end

  assign STAGE_RST = stage_rst_q;
  assign SEQ_DONE  = seq_done_q;
  assign SEQ_ERR   = seq_err_q;
  assign CUR_STAGE = cur_stage_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rst_seq_ctrl : self-checking bench for rst_seq_ctrl (N=3, HOLD=4, TO=8).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  localparam int N = 3;
  localparam int H = 4;
  localparam int T = 8;

  logic         CLK;
  logic         RST;
  logic         SW_RST_REQ;
  logic [N-1:0] STAGE_DONE;
  logic [N-1:0] STAGE_RST;
  logic         SEQ_DONE;
  logic         SEQ_ERR;
  logic [2:0]   CUR_STAGE;

  int errors = 0;
  int checks = 0;

  rst_seq_ctrl #(
    .NUM_STAGES (N),
    .HOLD_CYCLES(H),
    .TIMEOUT    (T),
    .CNT_WIDTH  (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW_RST_REQ(SW_RST_REQ),
    .STAGE_DONE(STAGE_DONE),
    .STAGE_RST (STAGE_RST),
    .SEQ_DONE  (SEQ_DONE),
    .SEQ_ERR   (SEQ_ERR),
    .CUR_STAGE (CUR_STAGE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] obs;
  assign obs = {STAGE_RST, SEQ_DONE, SEQ_ERR, CUR_STAGE};

  // Reference model: number of released stages, elapsed cycles in the
  // current phase, and the done/error flags.
  int m_rel, m_cur, m_elapsed;
  bit m_done, m_err;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_rel <= 0; m_cur <= 0; m_elapsed <= 0; m_done <= 0; m_err <= 0;
    end else if (SW_RST_REQ) begin
      m_rel <= 0; m_cur <= 0; m_elapsed <= 0; m_done <= 0; m_err <= 0;
    end else if (m_err || m_done) begin
      m_elapsed <= m_elapsed;
    end else if (m_rel == 0) begin
      if (m_elapsed + 1 == H) begin
        m_rel <= 1; m_cur <= 0; m_elapsed <= 0;
      end else begin
        m_elapsed <= m_elapsed + 1;
      end
    end else if (|((STAGE_DONE >> (m_rel - 1)) & 3'b001)) begin
      if (m_rel == N) m_done <= 1;
      else begin
        m_rel <= m_rel + 1; m_cur <= m_rel; m_elapsed <= 0;
      end
    end else if (m_elapsed + 1 == T) begin
      m_err <= 1; m_rel <= 0;
    end else begin
      m_elapsed <= m_elapsed + 1;
    end
  end

  function automatic logic [7:0] exp_vec();
    logic [2:0] r;
    r = 3'b111 << m_rel;
    return {r, m_done, m_err, 3'(m_cur)};
  endfunction

  // Expected outputs e edges after reset release with all done bits high.
  function automatic logic [7:0] pu_exp(int e);
    logic [2:0] r;
    int c;
    r = (e < H) ? 3'b111 : (3'b111 << (e - H + 1));
    c = (e <= H) ? 0 : ((e - H > N - 1) ? N - 1 : e - H);
    return {r, (e >= H + N) ? 1'b1 : 1'b0, 1'b0, 3'(c)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic restart();
    RST = 1'b1;
    SW_RST_REQ = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (STAGE_RST !== 3'b111) begin
      errors++; $display("FAIL reset_stage_rst: got %b want 111", STAGE_RST);
    end
    checks++;
    if (SEQ_DONE !== 1'b0 || SEQ_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got done=%b err=%b want 0 0", SEQ_DONE, SEQ_ERR);
    end
    checks++;
    if (CUR_STAGE !== 3'd0) begin
      errors++; $display("FAIL reset_cur_stage: got %0d want 0", CUR_STAGE);
    end
  endtask

  task automatic test_powerup();
    STAGE_DONE = 3'b111;
    restart();
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (obs !== pu_exp(e)) begin
        errors++; $display("FAIL powerup_edge%0d: got %b want %b", e, obs, pu_exp(e));
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL powerup_model_edge%0d: got %b want %b", e, obs, exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    STAGE_DONE = 3'b101;
    restart();
    for (int e = 1; e <= 33; e++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL timeout_model_edge%0d: got %b want %b", e, obs, exp_vec());
      end
      if (e >= 5 && e < 13) begin
        checks++;
        if (obs !== 8'b100_0_0_001) begin
          errors++; $display("FAIL timeout_wait_edge%0d: got %b want 10000001", e, obs);
        end
      end else if (e >= 13) begin
        checks++;
        if (obs !== 8'b111_0_1_001) begin
          errors++; $display("FAIL timeout_err_edge%0d: got %b want 11101001", e, obs);
        end
      end
    end
  endtask

  task automatic test_late_done();
    STAGE_DONE = 3'b101;
    restart();
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL late_model_edge%0d: got %b want %b", e, obs, exp_vec());
      end
      if (e == 12) begin
        checks++;
        if (obs !== 8'b100_0_0_001) begin
          errors++; $display("FAIL late_edge12: got %b want 10000001", obs);
        end
        STAGE_DONE = 3'b111;
      end else if (e == 13) begin
        checks++;
        if (obs !== 8'b000_0_0_010) begin
          errors++; $display("FAIL late_edge13: got %b want 00000010", obs);
        end
      end else if (e == 14) begin
        checks++;
        if (obs !== 8'b000_1_0_010) begin
          errors++; $display("FAIL late_edge14: got %b want 00010010", obs);
        end
      end
    end
  endtask

  task automatic test_sw_req();
    for (int ctx = 0; ctx < 3; ctx++) begin
      STAGE_DONE = (ctx == 2) ? 3'b111 : 3'b101;
      restart();
      for (int e = 0; e < ((ctx == 0) ? 13 : (ctx == 1) ? 7 : 8); e++) tick();
      SW_RST_REQ = 1'b1;
      STAGE_DONE = 3'b111;
      tick();
      SW_RST_REQ = 1'b0;
      checks++;
      if (obs !== 8'b111_0_0_000) begin
        errors++; $display("FAIL swreq_ctx%0d_pulse: got %b want 11100000", ctx, obs);
      end
      for (int j = 1; j <= 8; j++) begin
        tick();
        checks++;
        if (obs !== pu_exp(j)) begin
          errors++; $display("FAIL swreq_ctx%0d_edge%0d: got %b want %b", ctx, j, obs, pu_exp(j));
        end
        checks++;
        if (obs !== exp_vec()) begin
          errors++; $display("FAIL swreq_model_ctx%0d_edge%0d: got %b want %b", ctx, j, obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_early_done();
    STAGE_DONE = 3'b110;
    restart();
    for (int e = 1; e <= 4; e++) tick();
    for (int e = 5; e <= 9; e++) begin
      tick();
      checks++;
      if (obs !== 8'b110_0_0_000 || obs !== exp_vec()) begin
        errors++; $display("FAIL early_hold_edge%0d: got %b want 11000000", e, obs);
      end
    end
    STAGE_DONE = 3'b111;
    for (int e = 10; e <= 12; e++) begin
      tick();
      checks++;
      if (obs !== ((e == 10) ? 8'b100_0_0_001 : (e == 11) ? 8'b000_0_0_010 : 8'b000_1_0_010)) begin
        errors++; $display("FAIL early_release_edge%0d: got %b", e, obs);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL early_model_edge%0d: got %b want %b", e, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_rst();
    STAGE_DONE = 3'b101;
    restart();
    for (int e = 0; e < 7; e++) tick();
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if (obs !== 8'b111_0_0_000) begin
      errors++; $display("FAIL async_rst_immediate: got %b want 11100000", obs);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL async_rst_model: got %b want %b", obs, exp_vec());
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    STAGE_DONE = 3'b111;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (obs !== pu_exp(e)) begin
        errors++; $display("FAIL async_rst_replay_edge%0d: got %b want %b", e, obs, pu_exp(e));
      end
    end
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 800; c++) begin
      STAGE_DONE = 3'($urandom) & 3'($urandom);
      SW_RST_REQ = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %b want %b (done_in=%b sw=%b)", c, obs, exp_vec(), STAGE_DONE, SW_RST_REQ);
      end
    end
    SW_RST_REQ = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    SW_RST_REQ = 1'b0;
    STAGE_DONE = '0;
    #1;
    RST = 1'b1;
    #1;
    test_reset();
    test_powerup();
    test_timeout();
    test_late_done();
    test_sw_req();
    test_early_done();
    test_async_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
